// File: rtl/serial_byte_collector_if.sv
// Bus bundle for serial_byte_collector: the serial input side, the
// valid/ready output side and the status/clear signals.
interface serial_byte_collector_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             serialIn;
   logic             bitValid;
   logic             dir;
   logic             align;
   logic             outReady;
   logic             clrOverflow;
   logic [WIDTH-1:0] outData;
   logic             outValid;
   logic [CW-1:0]    count;
   logic             busy;
   logic             overflow;

   // Producer of the serial stream and consumer of assembled words
   modport master (
      output serialIn, bitValid, dir, align, outReady, clrOverflow,
      input  outData, outValid, count, busy, overflow
   );

   // The collector itself
   modport slave (
      input  serialIn, bitValid, dir, align, outReady, clrOverflow,
      output outData, outValid, count, busy, overflow
   );
endinterface

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel word collector with a small first-word-fall-through
// FIFO on its output. Bit order per word is chosen by dir, latched with
// the first bit of the word so a mid-word dir change cannot corrupt it.
module serial_byte_collector #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_byte_collector_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(WIDTH);

   logic [BW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_acc;
   logic             r_dir;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic [BW-1:0]    w_cnt_base;
   logic             w_first_bit;
   logic             w_dir_eff;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_done;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // align restarts the word before the current bit is counted, so an
   // aligned bit is treated exactly like bit 0 of a fresh word
   assign w_cnt_base  = bus.align ? '0 : r_bit_cnt;
   assign w_first_bit = (w_cnt_base == '0);
   assign w_dir_eff   = w_first_bit ? bus.dir : r_dir;
   assign w_acc_next  = w_dir_eff ? {bus.serialIn, r_acc[WIDTH-1:1]}
                                  : {r_acc[WIDTH-2:0], bus.serialIn};
   assign w_done      = bus.bitValid && (w_cnt_base == BW'(WIDTH - 1));

   // Full/empty come from the occupancy count; a pop at the same edge
   // frees the slot a full-FIFO completion needs
   assign w_full = (r_count == CW'(DEPTH));
   assign w_pop  = (r_count != '0) && bus.outReady;
   assign w_push = w_done && (!w_full || w_pop);
   assign w_drop = w_done && w_full && !w_pop;

   // Bit counter, accumulator and latched bit order
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bit_cnt <= '0;
         r_acc     <= '0;
         r_dir     <= 1'b0;
      end else begin
         if (bus.bitValid) begin
            r_acc <= w_acc_next;
            if (w_first_bit)
               r_dir <= bus.dir;
            r_bit_cnt <= w_done ? '0 : w_cnt_base + BW'(1);
         end else if (bus.align) begin
            r_bit_cnt <= '0;
         end
      end
   end

   // FIFO storage; contents need no reset since outData is masked when empty
   always_ff @(posedge clk) begin
      if (reset && w_push)
         r_mem[r_wr_ptr] <= w_acc_next;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (!reset)
         r_overflow <= 1'b0;
      else if (w_drop)
         r_overflow <= 1'b1;
      else if (bus.clrOverflow)
         r_overflow <= 1'b0;
   end

   assign bus.outValid = (r_count != '0);
   assign bus.outData  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign bus.count    = r_count;
   assign bus.busy     = (r_bit_cnt != '0);
   assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_byte_collector.sv
// Randomized and directed bench for serial_byte_collector. A word-level
// reference model predicts FIFO contents and status; a separate monitor
// compares every popped word against the predicted queue.
module tb_serial_byte_collector;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_byte_collector_if #(.WIDTH(W), .DEPTH(D)) bus();

   serial_byte_collector #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   int           m_bits[$];
   bit           m_wdir;
   int           m_cnt;
   bit           m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] assemble(input int bits[$], input bit d);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W; i++) begin
         if (d) v[i] = bits[i][0];
         else   v[W-1-i] = bits[i][0];
      end
      return v;
   endfunction

   // Advance the model for the upcoming edge, take the edge, check status
   task automatic cycle();
      bit pop, done, push, drop;
      logic [W-1:0] word;
      word = '0;
      done = 1'b0;
      if (!reset) begin
         m_bits.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         exp_q.delete();
      end else begin
         pop = (m_cnt > 0) && bus.outReady;
         if (bus.align) m_bits.delete();
         if (bus.bitValid) begin
            if (m_bits.size() == 0) m_wdir = bus.dir;
            m_bits.push_back(int'(bus.serialIn));
            if (m_bits.size() == W) begin
               done = 1'b1;
               word = assemble(m_bits, m_wdir);
               m_bits.delete();
            end
         end
         push = done && ((m_cnt < D) || pop);
         drop = done && !push;
         if (push) exp_q.push_back(word);
         m_cnt = m_cnt + int'(push) - int'(pop);
         if (drop) m_ovf = 1'b1;
         else if (bus.clrOverflow) m_ovf = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("count", 32'(bus.count), 32'(m_cnt));
      chk("outValid", 32'(bus.outValid), 32'(m_cnt > 0));
      chk("busy", 32'(bus.busy), 32'(m_bits.size() != 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
   endtask

   task automatic drv(input bit rst_n, input bit bv, input bit si, input bit d,
                      input bit al, input bit rdy, input bit clr);
      reset           = rst_n;
      bus.bitValid    = bv;
      bus.serialIn    = si;
      bus.dir         = d;
      bus.align       = al;
      bus.outReady    = rdy;
      bus.clrOverflow = clr;
      cycle();
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit d, input bit rdy_last);
      for (int i = 0; i < W; i++)
         drv(1, 1, d ? w[i] : w[W-1-i], d, 0, (i == W-1) ? rdy_last : 1'b0, 0);
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 1, 0);
   endtask

   // Monitor: each accepted word must match the head of the predicted queue
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_unexpected: got %0h expected no word", bus.outData);
         end else begin
            chk("pop_data", 32'(bus.outData), 32'(exp_q.pop_front()));
         end
      end else if (reset === 1'b1 && bus.outValid === 1'b0) begin
         chk("empty_data", 32'(bus.outData), 32'h0);
      end
   end

   initial begin
      logic [7:0] t2_bits;
      logic [6:0] t5_bits;
      reset = 1'b0;
      bus.bitValid = 0; bus.serialIn = 0; bus.dir = 0;
      bus.align = 0; bus.outReady = 0; bus.clrOverflow = 0;

      // Reset, then a basic MSB-first word
      drv(0, 0, 0, 0, 0, 0, 0);
      send_word(8'h09, 0, 0);
      chk("t1_data", 32'(bus.outData), 32'h09);
      chk("t1_count", 32'(bus.count), 32'd1);
      pop_n(1);
      chk("t1_after_pop", 32'(bus.outData), 32'h0);

      // LSB-first word with dir forced low from bit 3 onward
      t2_bits = 8'b0001_1100;
      for (int i = 0; i < 8; i++) drv(1, 1, t2_bits[i], i < 3, 0, 0, 0);
      chk("t2_data", 32'(bus.outData), 32'h1C);
      pop_n(1);

      // Overflow on a fifth word, drain, then clear
      for (int k = 1; k <= 5; k++) send_word(8'(k), 0, 0);
      chk("t3_count", 32'(bus.count), 32'd4);
      chk("t3_ovf", 32'(bus.overflow), 32'd1);
      pop_n(4);
      drv(1, 0, 0, 0, 0, 0, 1);
      chk("t3_clr", 32'(bus.overflow), 32'd0);

      // Completion on a full FIFO coinciding with a pop
      for (int k = 1; k <= 4; k++) send_word(8'(k), 0, 0);
      send_word(8'hAA, 0, 1);
      chk("t4_ovf", 32'(bus.overflow), 32'd0);
      chk("t4_count", 32'(bus.count), 32'd4);
      pop_n(4);

      // align mid-word
      for (int i = 0; i < 3; i++) drv(1, 1, 1, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 1, 0, 0);
      t5_bits = 7'b1010101;
      for (int i = 6; i >= 0; i--) drv(1, 1, t5_bits[i], 0, 0, 0, 0);
      chk("t5_data", 32'(bus.outData), 32'h55);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      pop_n(1);

      // Reset with words buffered and a partial word in progress
      send_word(8'h3C, 0, 0);
      send_word(8'hC3, 0, 0);
      for (int i = 0; i < 5; i++) drv(1, 1, 1, 0, 0, 0, 0);
      drv(0, 1, 1, 0, 0, 0, 0);
      chk("t6_count", 32'(bus.count), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      send_word(8'h5A, 1, 0);
      chk("t6_fresh", 32'(bus.outData), 32'h5A);
      pop_n(1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit rst_n;
         rst_n = ($urandom_range(0, 299) != 0);
         drv(rst_n,
             $urandom_range(0, 3) != 0,
             1'($urandom),
             1'($urandom),
             $urandom_range(0, 15) == 0,
             rst_n ? 1'($urandom) : 1'b0,
             $urandom_range(0, 19) == 0);
      end
      pop_n(D + 1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
